// File: rtl/absorb_stream.sv
// absorb_stream: streaming sponge absorb controller.
// Takes message blocks over valid/ready, pads the final partial block, and
// drives an external permutation core through f_start/f_done, one block at
// a time. Optional error detection is built when ABSORB_STREAM_ERR_EN is
// defined, which adds the err output and the ERR state.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for start
// ACCEPT | in_ready high, waiting for a message block
// LAUNCH | f_start pulse, block and state presented to permutation
// WAIT   | waiting for f_done from the permutation
// DONE   | final result held on cout/rout/xout, done high
// ERR    | bad final length or counter overflow (ERR_EN builds only)
module absorb_stream #(
  parameter int CWIDTH   = 320,
  parameter int RWIDTH   = 32,
  parameter int XWIDTH   = 64,
  parameter int IWIDTH   = 128,
  parameter int CNTWIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CWIDTH-1:0]         c_in,
  input  logic [RWIDTH-1:0]         r_in,
  input  logic [XWIDTH-1:0]         x_in,
  input  logic [1:0]                domain,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [IWIDTH-1:0]         in_data,
  input  logic                      in_last,
  input  logic [$clog2(IWIDTH/8):0] in_bytes,
  output logic                      f_start,
  output logic [CWIDTH-1:0]         f_c,
  output logic [RWIDTH-1:0]         f_r,
  output logic [XWIDTH-1:0]         f_x,
  output logic [IWIDTH-1:0]         f_i,
  output logic [3:0]                f_ds,
  input  logic                      f_done,
  input  logic [CWIDTH-1:0]         f_cout,
  input  logic [RWIDTH-1:0]         f_rout,
  input  logic [XWIDTH-1:0]         f_xout,
  output logic [CWIDTH-1:0]         cout,
  output logic [RWIDTH-1:0]         rout,
  output logic [XWIDTH-1:0]         xout,
  output logic [CNTWIDTH-1:0]       block_count,
  output logic                      busy,
  output logic                      done
`ifdef ABSORB_STREAM_ERR_EN
  ,
  output logic                      err
`endif
);

  localparam int NB = IWIDTH / 8;
  localparam int BW = $clog2(NB) + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_LAUNCH,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t              state_q, state_d;
  logic [CWIDTH-1:0]   c_q, c_d;
  logic [RWIDTH-1:0]   r_q, r_d;
  logic [XWIDTH-1:0]   x_q, x_d;
  logic [1:0]          dom_q, dom_d;
  logic                fin_q, fin_d;
  logic [IWIDTH-1:0]   fi_q, fi_d;
  logic [3:0]          fds_q, fds_d;
  logic [CWIDTH-1:0]   cout_q, cout_d;
  logic [RWIDTH-1:0]   rout_q, rout_d;
  logic [XWIDTH-1:0]   xout_q, xout_d;
  logic [CNTWIDTH-1:0] cnt_q, cnt_d;
  logic                f_start_q, f_start_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef ABSORB_STREAM_ERR_EN
  logic                err_q, err_d;
`endif

  logic                pad_en;
  logic [IWIDTH-1:0]   blk_pad;
  logic                bad_blk;

  // Pad a short final block: keep bytes below in_bytes, 0x01 marker, zeros above.
  always_comb begin
    pad_en  = in_last && (in_bytes < BW'(NB));
    blk_pad = in_data;
    if (pad_en) begin
      for (int k = 0; k < NB; k++) begin
        if (BW'(k) == in_bytes) begin
          blk_pad[8*k +: 8] = 8'h01;
        end else if (BW'(k) > in_bytes) begin
          blk_pad[8*k +: 8] = 8'h00;
        end
      end
    end
  end

  // Blocks that must not reach the permutation (only detected in ERR_EN builds).
`ifdef ABSORB_STREAM_ERR_EN
  assign bad_blk = (in_last && (in_bytes > BW'(NB))) || (cnt_q == '1);
`else
  assign bad_blk = 1'b0;
`endif

  // Next-state and datapath update; status outputs are decoded from the next state.
  always_comb begin
    state_d = state_q;
    c_d     = c_q;
    r_d     = r_q;
    x_d     = x_q;
    dom_d   = dom_q;
    fin_d   = fin_q;
    fi_d    = fi_q;
    fds_d   = fds_q;
    cout_d  = cout_q;
    rout_d  = rout_q;
    xout_d  = xout_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          c_d     = c_in;
          r_d     = r_in;
          x_d     = x_in;
          dom_d   = domain;
          cnt_d   = '0;
          state_d = ST_ACCEPT;
        end
      end
      ST_ACCEPT: begin
        if (in_valid) begin
          if (bad_blk) begin
            state_d = ST_ERR;
          end else begin
            fi_d    = blk_pad;
            fin_d   = in_last;
            fds_d   = {dom_q, in_last, pad_en};
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (f_done) begin
          c_d = f_cout;
          r_d = f_rout;
          x_d = f_xout;
          if (fin_q) begin
            cout_d  = f_cout;
            rout_d  = f_rout;
            xout_d  = f_xout;
            state_d = ST_DONE;
          end else begin
            state_d = ST_ACCEPT;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    in_ready_d = (state_d == ST_ACCEPT);
    f_start_d  = (state_d == ST_LAUNCH);
    busy_d     = (state_d == ST_ACCEPT) || (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
    done_d     = (state_d == ST_DONE);
`ifdef ABSORB_STREAM_ERR_EN
    err_d      = (state_d == ST_ERR);
`endif
  end

  // All state and registered outputs, synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      c_q        <= '0;
      r_q        <= '0;
      x_q        <= '0;
      dom_q      <= '0;
      fin_q      <= 1'b0;
      fi_q       <= '0;
      fds_q      <= '0;
      cout_q     <= '0;
      rout_q     <= '0;
      xout_q     <= '0;
      cnt_q      <= '0;
      f_start_q  <= 1'b0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef ABSORB_STREAM_ERR_EN
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      c_q        <= c_d;
      r_q        <= r_d;
      x_q        <= x_d;
      dom_q      <= dom_d;
      fin_q      <= fin_d;
      fi_q       <= fi_d;
      fds_q      <= fds_d;
      cout_q     <= cout_d;
      rout_q     <= rout_d;
      xout_q     <= xout_d;
      cnt_q      <= cnt_d;
      f_start_q  <= f_start_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef ABSORB_STREAM_ERR_EN
      err_q      <= err_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign f_start     = f_start_q;
  assign f_c         = c_q;
  assign f_r         = r_q;
  assign f_x         = x_q;
  assign f_i         = fi_q;
  assign f_ds        = fds_q;
  assign cout        = cout_q;
  assign rout        = rout_q;
  assign xout        = xout_q;
  assign block_count = cnt_q;
  assign busy        = busy_q;
  assign done        = done_q;
`ifdef ABSORB_STREAM_ERR_EN
  assign err         = err_q;
`endif

endmodule
